// File: rtl/abus_pkg.sv
// Shared definitions for the ABUS master port: FSM state encoding, master-id
// width and the strobe/keep width helper.
package abus_pkg;

  localparam int MID_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ABORT = 2'd2,
    RESP  = 2'd3
  } abus_state_e;

  // Ceiling log2; strobe/keep fields are abus_clog2(DATA_WIDTH + 1) bits wide.
  function automatic int abus_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/abus_master_port_if.sv
// Command/response handshake and ABUS master-side signals of one master port.
// The master modport is the port's own view; slave is the client/bus side.
interface abus_master_port_if
  import abus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  localparam int SW = abus_clog2(DATA_WIDTH + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [SW-1:0]         cmd_strb;
  logic [SW-1:0]         cmd_keep;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  logic [MID_WIDTH-1:0]  abus_mid;
  logic                  abus_mreq;
  logic                  abus_mwrite;
  logic                  abus_mread;
  logic                  abus_mabort;
  logic [SW-1:0]         abus_mstrb;
  logic [SW-1:0]         abus_mkeep;
  logic [DATA_WIDTH-1:0] abus_mwdata;
  logic [ADDR_WIDTH-1:0] abus_maddress;
  logic                  abus_mgrant;
  logic                  abus_mack;
  logic [DATA_WIDTH-1:0] abus_mrdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata, cmd_strb, cmd_keep,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    input  rsp_ready,
    output abus_mid, abus_mreq, abus_mwrite, abus_mread, abus_mabort,
    output abus_mstrb, abus_mkeep, abus_mwdata, abus_maddress,
    input  abus_mgrant, abus_mack, abus_mrdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata, cmd_strb, cmd_keep,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    output rsp_ready,
    input  abus_mid, abus_mreq, abus_mwrite, abus_mread, abus_mabort,
    input  abus_mstrb, abus_mkeep, abus_mwdata, abus_maddress,
    output abus_mgrant, abus_mack, abus_mrdata
  );

endinterface

// File: rtl/abus_timeout.sv
// Ack-wait counter for the ABUS master port: cleared when a command is
// accepted, advanced on each REQ cycle without a counted ack.
module abus_timeout
  import abus_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic abus_clk,
  input  logic abus_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = abus_clog2(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/abus_master_port.sv
// ABUS master port: turns one command into a single bus transfer and returns
// one response. Optional ack timeout/abort is built when ABUS_MASTER_TIMEOUT_EN
// is defined; otherwise REQ waits for an ack indefinitely.
module abus_master_port
  import abus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MASTER_ID  = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic                abus_clk,
  input  logic                abus_rst,
  abus_master_port_if.master  bus
);

  localparam int SW = abus_clog2(DATA_WIDTH + 1);
  localparam logic [MID_WIDTH-1:0] MID = MID_WIDTH'(MASTER_ID);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("abus_master_port: TIMEOUT must be at least 2");
  end

  abus_state_e state, next_state;

  logic                  cmd_ready_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         strb_q;
  logic [SW-1:0]         keep_q;

  logic                  mreq_q;
  logic                  mwrite_q;
  logic                  mread_q;
  logic [MID_WIDTH-1:0]  mid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic accept;
  logic ack_counted;
  logic write_d;
  logic mreq_d;

  assign accept      = bus.cmd_valid & cmd_ready_q;
  // A shared ack belongs to this master only while its grant bit is set.
  assign ack_counted = bus.abus_mack & bus.abus_mgrant;
  assign write_d     = accept ? bus.cmd_write : write_q;
  assign mreq_d      = (next_state == REQ) || (next_state == ABORT);

`ifdef ABUS_MASTER_TIMEOUT_EN
  logic expired;
  logic timeout_enable;
  logic mabort_q;
  logic rsp_error_q;

  assign timeout_enable = (state == REQ) && !ack_counted;

  abus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .abus_clk (abus_clk),
    .abus_rst (abus_rst),
    .clear    (accept),
    .enable   (timeout_enable),
    .expired  (expired)
  );
`endif

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) next_state = REQ;
      end
      REQ: begin
        if (ack_counted) begin
          next_state = RESP;
        end
`ifdef ABUS_MASTER_TIMEOUT_EN
        else if (expired) begin
          next_state = ABORT;
        end
`endif
      end
`ifdef ABUS_MASTER_TIMEOUT_EN
      ABORT: begin
        next_state = RESP;
      end
`endif
      RESP: begin
        if (bus.rsp_ready) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      mreq_q      <= 1'b0;
      mwrite_q    <= 1'b0;
      mread_q     <= 1'b0;
      mid_q       <= '0;
    end else begin
      state       <= next_state;
      cmd_ready_q <= (next_state == IDLE);
      mreq_q      <= mreq_d;
      mwrite_q    <= (next_state == REQ) && write_d;
      mread_q     <= (next_state == REQ) && !write_d;
      mid_q       <= mreq_d ? MID : '0;
    end
  end

  // Captured command fields drive the bus directly and only change on accept.
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      keep_q  <= '0;
    end else if (accept) begin
      write_q <= bus.cmd_write;
      addr_q  <= bus.cmd_address;
      wdata_q <= bus.cmd_wdata;
      strb_q  <= bus.cmd_strb;
      keep_q  <= bus.cmd_keep;
    end
  end

  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      rsp_rdata_q <= '0;
    end else if ((state == REQ) && ack_counted) begin
      rsp_rdata_q <= write_q ? '0 : bus.abus_mrdata;
    end
`ifdef ABUS_MASTER_TIMEOUT_EN
    else if (state == ABORT) begin
      rsp_rdata_q <= '0;
    end
`endif
  end

`ifdef ABUS_MASTER_TIMEOUT_EN
  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      mabort_q    <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      mabort_q <= (next_state == ABORT);
      if ((state == REQ) && ack_counted) begin
        rsp_error_q <= 1'b0;
      end else if (state == ABORT) begin
        rsp_error_q <= 1'b1;
      end
    end
  end

  assign bus.abus_mabort = mabort_q;
  assign bus.rsp_error   = rsp_error_q;
`else
  assign bus.abus_mabort = 1'b0;
  assign bus.rsp_error   = 1'b0;
`endif

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = (state == RESP);
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.abus_mid      = mid_q;
  assign bus.abus_mreq     = mreq_q;
  assign bus.abus_mwrite   = mwrite_q;
  assign bus.abus_mread    = mread_q;
  assign bus.abus_maddress = addr_q;
  assign bus.abus_mwdata   = wdata_q;
  assign bus.abus_mstrb    = strb_q;
  assign bus.abus_mkeep    = keep_q;

endmodule
